lc3_fetch_ctrl: RTL and testbench

Fetch-side controller at the responder end of the fetch_out bus. Drives enable_fetch and enable_updatePC into the Fetch stage and consumes its pc, npc and instrmem_rd. Inserts stalls for memory-access instructions and bubbles for control-flow instructions. Checks Fetch protocol compliance and counts fetched instructions.

---
 rtl/lc3_fetch_ctrl_pkg.sv | 20 ++
 rtl/lc3_fetch_proto_chk.sv | 34 +++
 rtl/lc3_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_lc3_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_fetch_ctrl_pkg.sv
// Shared types and defaults for the LC-3 fetch-side controller.
package lc3_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StMem,
    StCtrl
  } state_e;

  localparam int unsigned CtrlBubbleDefault = 3;
  localparam int unsigned MemTimeoutDefault = 15;
  localparam int unsigned CountWDefault     = 16;

  typedef struct packed {
    logic proto_err;
    logic tmo_err;
  } err_flags_t;

endpackage

// File: rtl/lc3_fetch_proto_chk.sv
// Combinational view of Fetch protocol violations; the top registers them into a sticky flag.
module lc3_fetch_proto_chk (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] npc_i,
  input  logic        rd_i,
  input  logic        en_fetch_i,
  input  logic        en_upc_i,
  input  logic        redirect_i,
  output logic        err_o
);

  logic        seq_arm_q;
  logic [15:0] npc_prev_q;

  // A plain sequential fetch cycle obliges the next pc to equal this cycle's npc.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_arm_q  <= 1'b0;
      npc_prev_q <= '0;
    end else begin
      seq_arm_q  <= en_fetch_i & en_upc_i & ~redirect_i;
      npc_prev_q <= npc_i;
    end
  end

  always_comb begin
    err_o = (rd_i & ~en_fetch_i)
          | (en_fetch_i & (npc_i != pc_i + 16'd1))
          | (seq_arm_q & (pc_i != npc_prev_q));
  end

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// Fetch-side controller: stalls for memory ops, bubbles for control flow, checks Fetch, counts fetches.
module lc3_fetch_ctrl
  import lc3_fetch_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_BUBBLE = CtrlBubbleDefault,
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned COUNT_W     = CountWDefault
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        pc,
  input  logic [15:0]        npc,
  input  logic               instrmem_rd,
  input  logic               mem_req,
  input  logic               ctrl_req,
  input  logic               br_taken,
  input  logic               complete_data,
  output logic               enable_fetch,
  output logic               enable_updatePC,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               stalled,
  output logic               proto_err,
  output logic               timeout_err
);

  localparam int unsigned BubW = $clog2(CTRL_BUBBLE + 1);
  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [BubW-1:0]    bub_q, bub_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic               br_q, br_d;
  logic               en_fetch_q, en_fetch_d;
  logic               en_upc_q, en_upc_d;
  logic               stalled_q, stalled_d;
  logic [COUNT_W-1:0] count_q, count_d;
  err_flags_t         err_q, err_d;
  logic               fsm_proto, tmo_hit, chk_err, redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      bub_q      <= '0;
      tmo_q      <= '0;
      br_q       <= 1'b0;
      en_fetch_q <= 1'b0;
      en_upc_q   <= 1'b0;
      stalled_q  <= 1'b0;
      count_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      bub_q      <= bub_d;
      tmo_q      <= tmo_d;
      br_q       <= br_d;
      en_fetch_q <= en_fetch_d;
      en_upc_q   <= en_upc_d;
      stalled_q  <= stalled_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    tmo_d     = tmo_q;
    br_d      = br_q;
    fsm_proto = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d   = StFetch;
        fsm_proto = mem_req | ctrl_req;
      end
      StFetch: begin
        if (ctrl_req) begin
          state_d   = StCtrl;
          bub_d     = BubW'(CTRL_BUBBLE - 1);
          br_d      = br_taken;
          fsm_proto = mem_req;
        end else if (mem_req) begin
          state_d = StMem;
          tmo_d   = '0;
        end
      end
      StMem: begin
        fsm_proto = mem_req | ctrl_req;
        // A completion on the timeout cycle wins: normal exit, no error.
        if (complete_data) begin
          state_d = StFetch;
        end else if (tmo_q == TmoW'(MEM_TIMEOUT - 1)) begin
          state_d = StFetch;
          tmo_hit = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCtrl: begin
        fsm_proto = mem_req | ctrl_req;
        if (bub_q == '0) begin
          state_d = StFetch;
        end else begin
          bub_d = bub_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    en_fetch_d      = (state_d == StFetch);
    en_upc_d        = (state_d == StFetch) || ((state_d == StCtrl) && (bub_d == '0));
    stalled_d       = (state_d != StFetch);
    count_d         = count_q + COUNT_W'(en_fetch_q & instrmem_rd);
    err_d.proto_err = err_q.proto_err | fsm_proto | chk_err;
    err_d.tmo_err   = err_q.tmo_err | tmo_hit;
  end

  assign redirect = en_upc_q & ~en_fetch_q & br_q;

  lc3_fetch_proto_chk u_proto_chk (
    .clk_i      (clock),
    .rst_i      (reset),
    .pc_i       (pc),
    .npc_i      (npc),
    .rd_i       (instrmem_rd),
    .en_fetch_i (en_fetch_q),
    .en_upc_i   (en_upc_q),
    .redirect_i (redirect),
    .err_o      (chk_err)
  );

  assign enable_fetch    = en_fetch_q;
  assign enable_updatePC = en_upc_q;
  assign fetch_count     = count_q;
  assign stalled         = stalled_q;
  assign proto_err       = err_q.proto_err;
  assign timeout_err     = err_q.tmo_err;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Self-checking bench: a behavioural Fetch stage plus a scenario-level model of enables, counts and flags.
module tb_lc3_fetch_ctrl;

  localparam int unsigned Bubble  = 3;
  localparam int unsigned Timeout = 15;

  logic        clock = 1'b0;
  logic        reset, instrmem_rd, mem_req, ctrl_req, br_taken, complete_data;
  logic [15:0] pc, npc;
  logic        enable_fetch, enable_updatePC, stalled, proto_err, timeout_err;
  logic [15:0] fetch_count;
  logic        enable_fetch4, enable_updatePC4, stalled4, proto_err4, timeout_err4;
  logic [3:0]  fetch_count4;

  int          checks = 0;
  int          failures = 0;
  int          exp_count;
  logic        exp_proto, exp_tmo, model_ef;
  logic        br_pend, npc_fault, rd_fault;
  logic [15:0] target;

  always #5 clock = ~clock;

  lc3_fetch_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .npc             (npc),
    .instrmem_rd     (instrmem_rd),
    .mem_req         (mem_req),
    .ctrl_req        (ctrl_req),
    .br_taken        (br_taken),
    .complete_data   (complete_data),
    .enable_fetch    (enable_fetch),
    .enable_updatePC (enable_updatePC),
    .fetch_count     (fetch_count),
    .stalled         (stalled),
    .proto_err       (proto_err),
    .timeout_err     (timeout_err)
  );

  lc3_fetch_ctrl #(.COUNT_W(4)) dut4 (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .npc             (npc),
    .instrmem_rd     (instrmem_rd),
    .mem_req         (mem_req),
    .ctrl_req        (ctrl_req),
    .br_taken        (br_taken),
    .complete_data   (complete_data),
    .enable_fetch    (enable_fetch4),
    .enable_updatePC (enable_updatePC4),
    .fetch_count     (fetch_count4),
    .stalled         (stalled4),
    .proto_err       (proto_err4),
    .timeout_err     (timeout_err4)
  );

  task automatic drive_fetch();
    npc         = pc + (npc_fault ? 16'd2 : 16'd1);
    instrmem_rd = (enable_fetch === 1'b1) | rd_fault;
  endtask

  // One clock edge; the Fetch model loads npc (or the branch target on a bubble pulse).
  task automatic tick();
    logic upc_pre, f_pre, rd_pre, rst_pre;
    upc_pre = (enable_updatePC === 1'b1);
    f_pre   = (enable_fetch === 1'b1);
    rd_pre  = instrmem_rd;
    rst_pre = reset;
    @(posedge clock);
    #1;
    if (rst_pre) exp_count = 0;
    else if (model_ef && rd_pre) exp_count++;
    if (upc_pre) begin
      pc = (!f_pre && br_pend) ? target : npc;
      if (!f_pre) br_pend = 1'b0;
    end
    mem_req       = 1'b0;
    ctrl_req      = 1'b0;
    br_taken      = 1'b0;
    complete_data = 1'b0;
    drive_fetch();
  endtask

  task automatic cyc(input logic ef, input logic eu, input string nm);
    tick();
    model_ef = ef;
    checks++;
    if (enable_fetch !== ef || enable_updatePC !== eu || stalled !== ~(ef & eu) ||
        enable_fetch4 !== ef) begin
      failures++;
      $display("FAIL %s enables: fetch/upc/stalled got %b%b%b want %b%b%b", nm,
               enable_fetch, enable_updatePC, stalled, ef, eu, ~(ef & eu));
    end
    checks++;
    if (fetch_count !== 16'(exp_count) || fetch_count4 !== 4'(exp_count)) begin
      failures++;
      $display("FAIL %s count: got %0d/%0d want %0d/%0d", nm, fetch_count, fetch_count4,
               16'(exp_count), 4'(exp_count));
    end
    checks++;
    if (proto_err !== exp_proto || timeout_err !== exp_tmo) begin
      failures++;
      $display("FAIL %s flags: proto/timeout got %b%b want %b%b", nm, proto_err, timeout_err,
               exp_proto, exp_tmo);
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    npc_fault = 1'b0;
    rd_fault  = 1'b0;
    drive_fetch();
    for (int i = 0; i < n; i++) begin
      tick();
      model_ef = 1'b0;
      checks++;
      if ({enable_fetch, enable_updatePC, stalled, proto_err, timeout_err} !== 5'b0 ||
          fetch_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_outputs: f/u/s/p/t got %b%b%b%b%b count %0d want 00000 count 0",
                 enable_fetch, enable_updatePC, stalled, proto_err, timeout_err, fetch_count);
      end
    end
    reset     = 1'b0;
    exp_proto = 1'b0;
    exp_tmo   = 1'b0;
    br_pend   = 1'b0;
  endtask

  task automatic do_mem(input int lat);
    int eff;
    eff = (lat < int'(Timeout)) ? lat : int'(Timeout);
    mem_req = 1'b1;
    cyc(1'b0, 1'b0, "mem_enter");
    for (int i = 1; i < eff; i++) cyc(1'b0, 1'b0, "mem_stall");
    complete_data = (lat <= int'(Timeout));
    if (lat > int'(Timeout)) exp_tmo = 1'b1;
    cyc(1'b1, 1'b1, "mem_exit");
  endtask

  task automatic do_ctrl(input logic b, input logic [15:0] tgt);
    ctrl_req = 1'b1;
    br_taken = b;
    br_pend  = b;
    target   = tgt;
    for (int i = 1; i <= int'(Bubble); i++) cyc(1'b0, (i == int'(Bubble)), "ctrl_bubble");
    cyc(1'b1, 1'b1, "ctrl_resume");
  endtask

  task automatic test_reset();
    pc = 16'h3000;
    do_reset(3);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, "reset_release");
  endtask

  task automatic test_mem_stall();
    do_mem(4);
    cyc(1'b1, 1'b1, "mem_after");
    do_mem(15);
    cyc(1'b1, 1'b1, "mem_edge_complete");
  endtask

  task automatic test_ctrl();
    do_ctrl(1'b1, 16'h4242);
    cyc(1'b1, 1'b1, "ctrl_after_taken");
    do_ctrl(1'b0, 16'h0);
    cyc(1'b1, 1'b1, "ctrl_after_not_taken");
  endtask

  task automatic test_timeout();
    do_mem(20);
    cyc(1'b1, 1'b1, "timeout_sticky");
  endtask

  task automatic test_both_req();
    do_reset(1);
    cyc(1'b1, 1'b1, "both_pre");
    mem_req   = 1'b1;
    ctrl_req  = 1'b1;
    exp_proto = 1'b1;
    for (int i = 1; i <= int'(Bubble); i++) cyc(1'b0, (i == int'(Bubble)), "both_bubble");
    cyc(1'b1, 1'b1, "both_resume");
  endtask

  task automatic test_reset_mid_ctrl();
    ctrl_req = 1'b1;
    cyc(1'b0, 1'b0, "midctrl_enter");
    do_reset(1);
    cyc(1'b1, 1'b1, "midctrl_release");
  endtask

  task automatic test_faults();
    do_reset(1);
    cyc(1'b1, 1'b1, "npcfault_pre");
    npc_fault = 1'b1;
    drive_fetch();
    exp_proto = 1'b1;
    cyc(1'b1, 1'b1, "npcfault_edge");
    npc_fault = 1'b0;
    drive_fetch();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, "npcfault_sticky");

    do_reset(1);
    cyc(1'b1, 1'b1, "rdfault_pre");
    mem_req = 1'b1;
    cyc(1'b0, 1'b0, "rdfault_stall");
    rd_fault = 1'b1;
    drive_fetch();
    exp_proto = 1'b1;
    cyc(1'b0, 1'b0, "rdfault_edge");
    rd_fault = 1'b0;
    drive_fetch();
    complete_data = 1'b1;
    cyc(1'b1, 1'b1, "rdfault_sticky");

    do_reset(1);
    cyc(1'b1, 1'b1, "outside_pre");
    mem_req = 1'b1;
    cyc(1'b0, 1'b0, "outside_stall");
    ctrl_req  = 1'b1;
    exp_proto = 1'b1;
    cyc(1'b0, 1'b0, "outside_ignored");
    complete_data = 1'b1;
    cyc(1'b1, 1'b1, "outside_exit");
  endtask

  task automatic test_count_wrap();
    do_reset(1);
    for (int i = 0; i < 40 && exp_count < 17; i++) cyc(1'b1, 1'b1, "wrap_fetch");
    checks++;
    if (exp_count != 17 || fetch_count4 !== 4'd1) begin
      failures++;
      $display("FAIL count_w4_wrap: got %0d after %0d fetches want 1 after 17", fetch_count4,
               exp_count);
    end
  endtask

  task automatic test_pc_wrap();
    pc = 16'hFFFD;
    do_reset(1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, "pc_wrap");
  endtask

  task automatic test_random();
    do_reset(2);
    cyc(1'b1, 1'b1, "rand_start");
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      case (op)
        0:       repeat ($urandom_range(1, 4)) cyc(1'b1, 1'b1, "rand_fetch");
        1:       do_mem(int'($urandom_range(1, 18)));
        default: do_ctrl(1'($urandom_range(0, 1)), 16'($urandom));
      endcase
    end
  endtask

  initial begin
    reset         = 1'b1;
    mem_req       = 1'b0;
    ctrl_req      = 1'b0;
    br_taken      = 1'b0;
    complete_data = 1'b0;
    npc_fault     = 1'b0;
    rd_fault      = 1'b0;
    br_pend       = 1'b0;
    target        = 16'h0;
    model_ef      = 1'b0;
    exp_count     = 0;
    exp_proto     = 1'b0;
    exp_tmo       = 1'b0;
    pc            = 16'h3000;
    instrmem_rd   = 1'b0;
    npc           = 16'h3001;

    test_reset();
    test_mem_stall();
    test_ctrl();
    test_timeout();
    test_both_req();
    test_reset_mid_ctrl();
    test_faults();
    test_count_wrap();
    test_pc_wrap();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
